blob_bbox_finder: RTL and testbench
===================================

Name: blob_bbox_finder

Overview:
- Downstream consumer and sequencer of the edge_search engine.
- Runs four directional edge searches over a caller-supplied frame (top, bottom, left, right) and narrows the frame after each hit.
- Reports the tight bounding box of all set pixels in the frame.
- Feeds the object-tracking logic; the edge engine and pixel cache sit below it.

Parameters:
- COORD_W, 10: width of every x/y coordinate.
- TIMEOUT_CYCLES, 4194303: maximum cycles to wait for one engine search before aborting.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- frame_x0, frame_y0, frame_x1, frame_y1  in  COORD_W each  inclusive search frame; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- bbox_valid  out  1  at least one pixel was found
- error  out  1  bad frame, timeout, or inconsistent engine result
- bbox_x0, bbox_y0, bbox_x1, bbox_y1  out  COORD_W each  result box, inclusive
- eng_rst  out  1  one-cycle reset to the edge engine; forces it to IDLE and clears its stale done
- eng_start  out  1  start to the edge engine
- eng_dir  out  2  engine direction: UP=00, DOWN=01, LEFT=10, RIGHT=11
- eng_x0, eng_y0, eng_x1, eng_y1  out  COORD_W each  engine frame
- eng_done, eng_found  in  1 each  engine status
- eng_hit_x, eng_hit_y  in  COORD_W each  tapped from the engine's pixel-address bus; valid when eng_done and eng_found

Behaviour:
- Reset values: every output 0; all frame and result registers 0; state IDLE.
- Reset mid-operation aborts the run immediately. No done pulse is produced; bbox_valid and error read 0.

States:
- IDLE → CHECK on start. Frame registers latch; busy goes high the next cycle.
- CHECK, 1 cycle:
  - If frame_x0 > frame_x1 or frame_y0 > frame_y1: error=1, bbox_valid=0, go to DONE.
  - Otherwise: phase=TOP, go to ENG_RST.
- ENG_RST, 1 cycle: eng_rst=1; eng_dir and eng_* frame are driven for the current phase.
- ENG_GO, 1 cycle: eng_start=1; timeout counter cleared.
- ENG_WAIT: waits for eng_done=1.
  - A stale eng_done is impossible here because ENG_RST cleared it.
  - Counter increments every cycle. If it reaches TIMEOUT_CYCLES: error=1, bbox_valid=0, go to DONE.
- EVAL, 1 cycle: on eng_done, latch eng_found, eng_hit_x, eng_hit_y, then apply the phase table below.
- DONE, 1 cycle: done=1, busy=0 on exit, return to IDLE.

Phase table (direction, engine frame, action on result):
- TOP: DOWN over (fx0, fy0)-(fx1, fy1).
  - Not found: bbox_valid=0, error=0, go to DONE.
  - Found: bbox_y0 = hit_y.
- BOTTOM: UP over (fx0, by0)-(fx1, fy1). Found: bbox_y1 = hit_y.
- LEFT_EDGE: RIGHT over (fx0, by0)-(fx1, by1). Found: bbox_x0 = hit_x.
- RIGHT_EDGE: LEFT over (bx0, by0)-(fx1, by1). Found: bbox_x1 = hit_x, bbox_valid=1, go to DONE.
- Not found in BOTTOM, LEFT_EDGE or RIGHT_EDGE is an inconsistent engine result: error=1, bbox_valid=0, go to DONE.
- After each found phase except RIGHT_EDGE, advance to the next phase via ENG_RST.

Run rules:
- start while busy is ignored.
- Frame inputs may change freely after acceptance.
- Results hold until the next accepted start. bbox_valid and error clear on acceptance.
- Fixed overhead is 4 cycles per phase (ENG_RST, ENG_GO, EVAL, plus the engine's own latency), plus 2 cycles for CHECK and DONE.
- All comparisons are unsigned.
- A single-pixel frame is legal. Hit coordinates equal to a frame bound are legal.

Decomposition:
- Shared package narwhal_pkg holds:
  - COORD_W
  - the search-direction enum with encodings UP=00, DOWN=01, LEFT=10, RIGHT=11, shared with edge_search
  - the bbox struct {x0, y0, x1, y1}
- No sub-module. The timeout counter and phase register are local to the block.

Test Plan:
- Image with pixels (7,2), (3,3), (9,4), (5,5); frame (2,2)-(10,10); start → done with bbox_valid=1, box (3,2)-(9,5), error=0.
- All-zero image, same frame → done after TOP phase only; bbox_valid=0, error=0; exactly one eng_start observed.
- Frame x0=8, x1=4 → done 2 cycles after start; error=1; eng_start never asserted.
- Single pixel (9,4), frame (9,4)-(9,4) → box (9,4)-(9,4), bbox_valid=1.
- Stub engine never asserts eng_done, TIMEOUT_CYCLES=50 → error=1 and done 50 cycles after the ENG_WAIT entry.
- start pulsed again mid-run is ignored and gives the same box; reset asserted during phase 2 → all outputs 0 the next cycle; a new run afterwards succeeds.

Source files
------------

// File: rtl/narwhal_pkg.sv
// narwhal_pkg: types shared by the edge-search engine and its consumers.
//   COORD_W      : width of every x/y pixel coordinate
//   search_dir_e : edge-engine scan direction (encoding shared with edge_search)
//   bbox_t       : inclusive rectangle {x0, y0, x1, y1}
//   bbox_phase_e : which edge of the bounding box is being searched for
package narwhal_pkg;

    localparam int unsigned COORD_W = 10;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } search_dir_e;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
    } bbox_t;

    typedef enum logic [1:0] {
        PhTop    = 2'b00,
        PhBottom = 2'b01,
        PhLeft   = 2'b10,
        PhRight  = 2'b11
    } bbox_phase_e;

endpackage

// File: rtl/blob_bbox_finder.sv
// blob_bbox_finder: sequences four edge-engine searches (top, bottom, left, right) over a
// caller frame, narrowing the frame after each hit, and reports the tight bounding box of
// all set pixels.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   start, frame_*                run request and inclusive frame (sampled when idle)
//   busy, done                    run in progress / one-cycle completion pulse
//   bbox_valid, error, bbox_*     result flags and inclusive box, held until next run
//   eng_rst, eng_start, eng_dir   edge-engine control
//   eng_x0/y0/x1/y1               edge-engine search frame
//   eng_done, eng_found, eng_hit_* edge-engine status and hit coordinate
module blob_bbox_finder
    import narwhal_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4194303
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] frame_x0,
    input  logic [COORD_W-1:0] frame_y0,
    input  logic [COORD_W-1:0] frame_x1,
    input  logic [COORD_W-1:0] frame_y1,
    output logic               busy,
    output logic               done,
    output logic               bbox_valid,
    output logic               error,
    output logic [COORD_W-1:0] bbox_x0,
    output logic [COORD_W-1:0] bbox_y0,
    output logic [COORD_W-1:0] bbox_x1,
    output logic [COORD_W-1:0] bbox_y1,
    output logic               eng_rst,
    output logic               eng_start,
    output logic [1:0]         eng_dir,
    output logic [COORD_W-1:0] eng_x0,
    output logic [COORD_W-1:0] eng_y0,
    output logic [COORD_W-1:0] eng_x1,
    output logic [COORD_W-1:0] eng_y1,
    input  logic               eng_done,
    input  logic               eng_found,
    input  logic [COORD_W-1:0] eng_hit_x,
    input  logic [COORD_W-1:0] eng_hit_y
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StEngRst,
        StEngGo,
        StEngWait,
        StEval,
        StDone
    } state_e;

    state_e             r_state;
    bbox_phase_e        r_phase;
    bbox_t              r_frame;
    bbox_t              r_bbox;
    logic [CntW-1:0]    r_cnt;
    logic               r_found;
    logic [COORD_W-1:0] r_hit_x;
    logic [COORD_W-1:0] r_hit_y;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;
    logic               r_error;
    logic               r_eng_rst;
    logic               r_eng_start;

    search_dir_e        w_dir;
    bbox_t              w_eng;

    // Engine frame for the current phase; each phase narrows by the edges found so far.
    always_comb begin
        w_dir = DIR_DOWN;
        w_eng = r_frame;
        unique case (r_phase)
            PhTop: begin
                w_dir = DIR_DOWN;
            end
            PhBottom: begin
                w_dir    = DIR_UP;
                w_eng.y0 = r_bbox.y0;
            end
            PhLeft: begin
                w_dir    = DIR_RIGHT;
                w_eng.y0 = r_bbox.y0;
                w_eng.y1 = r_bbox.y1;
            end
            PhRight: begin
                w_dir    = DIR_LEFT;
                w_eng.x0 = r_bbox.x0;
                w_eng.y0 = r_bbox.y0;
                w_eng.y1 = r_bbox.y1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_phase     <= PhTop;
            r_frame     <= '0;
            r_bbox      <= '0;
            r_cnt       <= '0;
            r_found     <= 1'b0;
            r_hit_x     <= '0;
            r_hit_y     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_eng_rst   <= 1'b0;
            r_eng_start <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_eng_rst   <= 1'b0;
            r_eng_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_frame <= '{x0: frame_x0, y0: frame_y0, x1: frame_x1, y1: frame_y1};
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_error <= 1'b0;
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    if (r_frame.x0 > r_frame.x1 || r_frame.y0 > r_frame.y1) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_phase   <= PhTop;
                        r_eng_rst <= 1'b1;
                        r_state   <= StEngRst;
                    end
                end
                StEngRst: begin
                    r_eng_start <= 1'b1;
                    r_state     <= StEngGo;
                end
                StEngGo: begin
                    r_cnt   <= '0;
                    r_state <= StEngWait;
                end
                StEngWait: begin
                    if (eng_done) begin
                        r_found <= eng_found;
                        r_hit_x <= eng_hit_x;
                        r_hit_y <= eng_hit_y;
                        r_state <= StEval;
                    end else if (r_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StEval: begin
                    if (!r_found) begin
                        // An empty frame is only legal on the first search; later misses
                        // contradict an earlier hit.
                        r_error <= (r_phase != PhTop);
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        unique case (r_phase)
                            PhTop:    r_bbox.y0 <= r_hit_y;
                            PhBottom: r_bbox.y1 <= r_hit_y;
                            PhLeft:   r_bbox.x0 <= r_hit_x;
                            PhRight:  r_bbox.x1 <= r_hit_x;
                        endcase
                        if (r_phase == PhRight) begin
                            r_valid <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_phase   <= bbox_phase_e'(r_phase + 2'd1);
                            r_eng_rst <= 1'b1;
                            r_state   <= StEngRst;
                        end
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign bbox_valid = r_valid;
    assign error      = r_error;
    assign bbox_x0    = r_bbox.x0;
    assign bbox_y0    = r_bbox.y0;
    assign bbox_x1    = r_bbox.x1;
    assign bbox_y1    = r_bbox.y1;
    assign eng_rst    = r_eng_rst;
    assign eng_start  = r_eng_start;
    // Engine bus idles at zero outside a run.
    assign eng_dir    = r_busy ? w_dir : 2'b00;
    assign eng_x0     = r_busy ? w_eng.x0 : '0;
    assign eng_y0     = r_busy ? w_eng.y0 : '0;
    assign eng_x1     = r_busy ? w_eng.x1 : '0;
    assign eng_y1     = r_busy ? w_eng.y1 : '0;

endmodule

// File: tb/tb_blob_bbox_finder.sv
// tb_blob_bbox_finder: drives blob_bbox_finder against a behavioural edge engine scanning a
// 32x32 image, and checks every result against a direct min/max bounding-box model.
module tb_blob_bbox_finder;
    import narwhal_pkg::*;

    localparam int unsigned TO = 50;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [COORD_W-1:0] frame_x0, frame_y0, frame_x1, frame_y1;
    logic               busy, done, bbox_valid, error;
    logic [COORD_W-1:0] bbox_x0, bbox_y0, bbox_x1, bbox_y1;
    logic               eng_rst, eng_start;
    logic [1:0]         eng_dir;
    logic [COORD_W-1:0] eng_x0, eng_y0, eng_x1, eng_y1;
    logic               eng_done, eng_found;
    logic [COORD_W-1:0] eng_hit_x, eng_hit_y;

    always #5 clk = ~clk;

    blob_bbox_finder #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .frame_x0(frame_x0), .frame_y0(frame_y0), .frame_x1(frame_x1), .frame_y1(frame_y1),
        .busy(busy), .done(done), .bbox_valid(bbox_valid), .error(error),
        .bbox_x0(bbox_x0), .bbox_y0(bbox_y0), .bbox_x1(bbox_x1), .bbox_y1(bbox_y1),
        .eng_rst(eng_rst), .eng_start(eng_start), .eng_dir(eng_dir),
        .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
        .eng_done(eng_done), .eng_found(eng_found),
        .eng_hit_x(eng_hit_x), .eng_hit_y(eng_hit_y)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit img [0:31][0:31];
    bit eng_hang;
    bit chk_en;

    // Expectations for the current run, written only by the stimulus process.
    bit exp_valid, exp_error, exp_bad, exp_to;
    int exp_x0, exp_y0, exp_x1, exp_y1, exp_ns;

    task automatic chk(input string name, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit px(input int x, input int y);
        if (x >= 0 && x < 32 && y >= 0 && y < 32) return img[y][x];
        return 1'b0;
    endfunction

    task automatic clear_img();
        foreach (img[y, x]) img[y][x] = 1'b0;
    endtask

    // Bounding box straight from the definition: min/max over set pixels inside the frame.
    task automatic model(input int fx0, input int fy0, input int fx1, input int fy1,
                         output bit v, output bit e, output int a, output int b,
                         output int c, output int d, output int ns);
        v = 0; e = 0; a = 0; b = 0; c = 0; d = 0; ns = 0;
        if (fx0 > fx1 || fy0 > fy1) begin
            e = 1;
            return;
        end
        ns = 1;
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 32; x++) begin
                if (img[y][x] && x >= fx0 && x <= fx1 && y >= fy0 && y <= fy1) begin
                    if (!v) begin
                        a = x; c = x; b = y; d = y; v = 1;
                    end else begin
                        if (x < a) a = x;
                        if (x > c) c = x;
                        if (y < b) b = y;
                        if (y > d) d = y;
                    end
                end
            end
        end
        if (v) ns = 4;
    endtask

    // Edge engine: first hit scanning in the given direction.
    task automatic search(input logic [1:0] dir, input int x0, input int y0, input int x1,
                          input int y1, output bit f, output int hx, output int hy);
        f = 0; hx = 0; hy = 0;
        case (dir)
            2'b01: for (int y = y0; y <= y1 && !f; y++)
                       for (int x = x0; x <= x1 && !f; x++)
                           if (px(x, y)) begin f = 1; hx = x; hy = y; end
            2'b00: for (int y = y1; y >= y0 && !f; y--)
                       for (int x = x0; x <= x1 && !f; x++)
                           if (px(x, y)) begin f = 1; hx = x; hy = y; end
            2'b11: for (int x = x0; x <= x1 && !f; x++)
                       for (int y = y0; y <= y1 && !f; y++)
                           if (px(x, y)) begin f = 1; hx = x; hy = y; end
            default: for (int x = x1; x >= x0 && !f; x--)
                       for (int y = y0; y <= y1 && !f; y++)
                           if (px(x, y)) begin f = 1; hx = x; hy = y; end
        endcase
    endtask

    initial begin
        int  cnt;
        bit  f;
        int  hx, hy;
        eng_done = 0; eng_found = 0; eng_hit_x = '0; eng_hit_y = '0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || eng_rst) begin
                eng_done = 0;
                cnt = 0;
            end else if (eng_start) begin
                search(eng_dir, int'(eng_x0), int'(eng_y0), int'(eng_x1), int'(eng_y1),
                       f, hx, hy);
                eng_found = f;
                eng_hit_x = COORD_W'(hx);
                eng_hit_y = COORD_W'(hy);
                cnt = eng_hang ? 0 : int'($urandom_range(1, 6));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) eng_done = 1;
            end
        end
    end

    // Compare process: every cycle while enabled, check in-flight, completion and held results.
    initial begin
        bit active, have_held, h_valid, h_error;
        int h_x0, h_y0, h_x1, h_y1;
        int lat, st_lat, n_start;
        active = 0; have_held = 0; lat = 0; st_lat = 0; n_start = 0;
        h_valid = 0; h_error = 0; h_x0 = 0; h_y0 = 0; h_x1 = 0; h_y1 = 0;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                active = 0;
                have_held = 0;
            end else begin
                if (active) lat++;
                if (eng_start) begin
                    n_start++;
                    st_lat = lat;
                end
                if (done) begin
                    chk("done_valid", bbox_valid, exp_valid);
                    chk("done_error", error, exp_error);
                    chk("done_busy", busy, 1);
                    if (exp_valid) begin
                        chk("bbox_x0", bbox_x0, exp_x0);
                        chk("bbox_y0", bbox_y0, exp_y0);
                        chk("bbox_x1", bbox_x1, exp_x1);
                        chk("bbox_y1", bbox_y1, exp_y1);
                    end
                    chk("eng_start_count", n_start, exp_ns);
                    if (exp_bad) chk("bad_frame_latency", lat, 2);
                    if (exp_to) chk("timeout_latency", lat - st_lat, TO + 1);
                    active = 0;
                    have_held = 1;
                    h_valid = exp_valid; h_error = exp_error;
                    h_x0 = exp_x0; h_y0 = exp_y0; h_x1 = exp_x1; h_y1 = exp_y1;
                end else if (busy) begin
                    chk("inflight_flags", {bbox_valid, error}, 0);
                end else if (have_held) begin
                    chk("hold_valid", bbox_valid, h_valid);
                    chk("hold_error", error, h_error);
                    if (h_valid) begin
                        chk("hold_box", {bbox_x0, bbox_y0, bbox_x1, bbox_y1},
                            {COORD_W'(h_x0), COORD_W'(h_y0), COORD_W'(h_x1), COORD_W'(h_y1)});
                    end
                end
                if (start && !busy) begin
                    active = 1;
                    lat = 0;
                    n_start = 0;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {busy, done, bbox_valid, error, eng_rst, eng_start, eng_dir}, 0);
        chk({tag, "_bbox"}, {bbox_x0, bbox_y0, bbox_x1, bbox_y1}, 0);
        chk({tag, "_engframe"}, {eng_x0, eng_y0, eng_x1, eng_y1}, 0);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("run_completed", seen, 1);
    endtask

    task automatic run(input int fx0, input int fy0, input int fx1, input int fy1,
                       input bit hang, input bit mid);
        bit v, e;
        int a, b, c, d, ns;
        model(fx0, fy0, fx1, fy1, v, e, a, b, c, d, ns);
        exp_bad = (fx0 > fx1 || fy0 > fy1);
        exp_to  = hang && !exp_bad;
        if (exp_to) begin
            v = 0; e = 1; ns = 1;
        end
        exp_valid = v; exp_error = e; exp_ns = ns;
        exp_x0 = a; exp_y0 = b; exp_x1 = c; exp_y1 = d;
        eng_hang = hang;
        @(posedge clk); #1;
        start = 1;
        frame_x0 = COORD_W'(fx0); frame_y0 = COORD_W'(fy0);
        frame_x1 = COORD_W'(fx1); frame_y1 = COORD_W'(fy1);
        @(posedge clk); #1;
        start = 0;
        frame_x0 = COORD_W'($urandom_range(0, 1023)); frame_y0 = COORD_W'($urandom_range(0, 1023));
        frame_x1 = COORD_W'($urandom_range(0, 1023)); frame_y1 = COORD_W'($urandom_range(0, 1023));
        if (mid) begin
            repeat (5) @(posedge clk);
            #1 start = 1;
            frame_x0 = 0; frame_y0 = 0; frame_x1 = 31; frame_y1 = 31;
            @(posedge clk); #1 start = 0;
        end
        wait_done();
        eng_hang = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic load_plan_img();
        clear_img();
        img[2][7] = 1; img[3][3] = 1; img[4][9] = 1; img[5][5] = 1;
    endtask

    initial begin
        bit v, e;
        int a, b, c, d, ns, seen;
        reset = 1; start = 0; chk_en = 0; eng_hang = 0;
        frame_x0 = '0; frame_y0 = '0; frame_x1 = '0; frame_y1 = '0;
        exp_valid = 0; exp_error = 0; exp_bad = 0; exp_to = 0; exp_ns = 0;
        exp_x0 = 0; exp_y0 = 0; exp_x1 = 0; exp_y1 = 0;
        clear_img();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 reset = 0;
        chk_en = 1;

        // Hand-computed pins on the model, then the same scenarios through the DUT.
        load_plan_img();
        model(2, 2, 10, 10, v, e, a, b, c, d, ns);
        chk("pin_plan_box", {a, b, c, d}, {32'd3, 32'd2, 32'd9, 32'd5});
        chk("pin_plan_flags", {v, e, ns[3:0]}, {1'b1, 1'b0, 4'd4});
        run(2, 2, 10, 10, 0, 0);

        clear_img();
        model(2, 2, 10, 10, v, e, a, b, c, d, ns);
        chk("pin_empty_flags", {v, e, ns[3:0]}, {1'b0, 1'b0, 4'd1});
        run(2, 2, 10, 10, 0, 0);

        load_plan_img();
        run(8, 2, 4, 10, 0, 0);

        img[4][9] = 1;
        model(9, 4, 9, 4, v, e, a, b, c, d, ns);
        chk("pin_single_box", {a, b, c, d}, {32'd9, 32'd4, 32'd9, 32'd4});
        run(9, 4, 9, 4, 0, 0);

        run(2, 2, 10, 10, 1, 0);
        run(2, 2, 10, 10, 0, 1);

        // Reset during the second phase aborts the run with everything cleared.
        @(posedge clk); #1 start = 1;
        frame_x0 = 2; frame_y0 = 2; frame_x1 = 10; frame_y1 = 10;
        chk_en = 0;
        @(posedge clk); #1 start = 0;
        seen = 0;
        for (int i = 0; i < 200 && seen < 2; i++) begin
            @(negedge clk);
            if (eng_start) seen++;
        end
        chk("reached_phase2", seen, 2);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check_all_zero("midrun_reset");
        @(negedge clk);
        chk("no_done_after_reset", {done, busy}, 0);
        chk_en = 1;
        run(2, 2, 10, 10, 0, 0);

        for (int r = 0; r < 40; r++) begin
            int fx0, fy0, fx1, fy1, t, k;
            clear_img();
            k = $urandom_range(0, 8);
            for (int i = 0; i < k; i++) img[$urandom_range(0, 31)][$urandom_range(0, 31)] = 1;
            fx0 = $urandom_range(0, 36); fx1 = $urandom_range(0, 36);
            fy0 = $urandom_range(0, 36); fy1 = $urandom_range(0, 36);
            if ($urandom_range(0, 5) != 0) begin
                if (fx0 > fx1) begin t = fx0; fx0 = fx1; fx1 = t; end
                if (fy0 > fy1) begin t = fy0; fy0 = fy1; fy1 = t; end
            end
            run(fx0, fy0, fx1, fy1, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
